ttt_turn_ctrl: RTL

TTT_TURN_CTRL -- requirements
Module: ttt_turn_ctrl

---
 rtl/ttt_pkg.sv | 41 ++++
 rtl/ttt_line_check.sv | 17 +
 rtl/ttt_turn_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn controller: FSM states, result codes,
// win-line masks and a cell-to-mask helper.
package ttt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_TURN,
    S_C_TURN,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_PLAYER = 2'b01;
  localparam logic [1:0] WHO_COMP   = 2'b10;
  localparam logic [1:0] WHO_DRAW   = 2'b11;

  // Cell k (1..9, row-major) maps to bit k-1.
  localparam logic [8:0] LINE_R0 = 9'h007;
  localparam logic [8:0] LINE_R1 = 9'h038;
  localparam logic [8:0] LINE_R2 = 9'h1C0;
  localparam logic [8:0] LINE_C0 = 9'h049;
  localparam logic [8:0] LINE_C1 = 9'h092;
  localparam logic [8:0] LINE_C2 = 9'h124;
  localparam logic [8:0] LINE_D0 = 9'h111;
  localparam logic [8:0] LINE_D1 = 9'h054;

  localparam int NUM_LINES = 8;
  localparam logic [NUM_LINES-1:0][8:0] WIN_LINES = {
    LINE_D1, LINE_D0, LINE_C2, LINE_C1, LINE_C0, LINE_R2, LINE_R1, LINE_R0
  };

  // One-hot cell mask; zero for positions outside 1..9.
  function automatic logic [8:0] pos_mask(input logic [3:0] pos);
    logic [8:0] m;
    m = '0;
    if (pos >= 4'd1 && pos <= 4'd9) m = 9'd1 << (pos - 4'd1);
    return m;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector over one side's 9-cell board.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [8:0] board,
  output logic       win
);

  logic [NUM_LINES-1:0] hit;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    assign hit[i] = (board & WIN_LINES[i]) == WIN_LINES[i];
  end

  assign win = |hit;

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn controller: alternates player/computer moves, validates cells,
// detects win/draw. Define TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES idle cycles.
module ttt_turn_ctrl
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       player_vld,
  input  logic [3:0] player_pos,
  output logic       player_rdy,
  input  logic       comp_vld,
  input  logic [3:0] comp_pos,
  output logic       comp_rdy,
  output logic       turn,
  output logic [8:0] board_p,
  output logic [8:0] board_c,
  output logic       illegal,
  output logic       game_over,
  output logic [1:0] who,
  output logic       timeout
);

  state_t     state_q, state_d;
  logic [8:0] board_p_d, board_c_d;
  logic       turn_d, illegal_d;
  logic [1:0] who_d;

  logic       win_p, win_c, mover_win;
  logic       mv_vld, mv_legal, tmo_hit;
  logic [3:0] mv_pos;
  logic [8:0] mv_mask, occupied;

  ttt_line_check u_chk_p (.board(board_p), .win(win_p));
  ttt_line_check u_chk_c (.board(board_c), .win(win_c));

  // turn still names the last mover while in CHECK; it flips on CHECK exit.
  assign mover_win  = turn ? win_c : win_p;
  assign occupied   = board_p | board_c;

  assign player_rdy = (state_q == S_P_TURN);
  assign comp_rdy   = (state_q == S_C_TURN);
  assign game_over  = (state_q == S_DONE);

  assign mv_vld   = (player_rdy && player_vld) || (comp_rdy && comp_vld);
  assign mv_pos   = comp_rdy ? comp_pos : player_pos;
  assign mv_mask  = pos_mask(mv_pos);
  assign mv_legal = (|mv_mask) && !(|(mv_mask & occupied));

  always_comb begin
    state_d   = state_q;
    board_p_d = board_p;
    board_c_d = board_c;
    turn_d    = turn;
    who_d     = who;
    illegal_d = 1'b0;
    if (play) begin
      // Restart beats any simultaneous move, which is dropped silently.
      state_d   = S_P_TURN;
      board_p_d = '0;
      board_c_d = '0;
      turn_d    = 1'b0;
      who_d     = WHO_NONE;
    end else begin
      case (state_q)
        S_P_TURN, S_C_TURN: begin
          if (mv_vld) begin
            if (mv_legal) begin
              if (player_rdy) board_p_d = board_p | mv_mask;
              else            board_c_d = board_c | mv_mask;
              state_d = S_CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end else if (tmo_hit) begin
            state_d = player_rdy ? S_C_TURN : S_P_TURN;
            turn_d  = ~turn;
          end
        end
        S_CHECK: begin
          if (mover_win) begin
            state_d = S_DONE;
            who_d   = turn ? WHO_COMP : WHO_PLAYER;
          end else if (&occupied) begin
            state_d = S_DONE;
            who_d   = WHO_DRAW;
          end else begin
            state_d = turn ? S_P_TURN : S_C_TURN;
            turn_d  = ~turn;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      board_p <= '0;
      board_c <= '0;
      turn    <= 1'b0;
      who     <= WHO_NONE;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      board_p <= board_p_d;
      board_c <= board_c_d;
      turn    <= turn_d;
      who     <= who_d;
      illegal <= illegal_d;
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             in_turn, cnt_clr;

  assign in_turn = player_rdy || comp_rdy;
  assign tmo_hit = in_turn && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // Any state change (incl. restart) or rejected move starts a fresh turn budget.
  assign cnt_clr = play || (state_d != state_q) || illegal_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= !play && in_turn && !mv_vld && tmo_hit;
      if (cnt_clr)      cnt_q <= '0;
      else if (in_turn) cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  // TIMEOUT_CYCLES only matters in the timeout build; this compare is constant false.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule
